// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: control-decoder opcodes, ALU op
// codes and the state encoding of the data-memory responder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with synchronous write and a registered read port.
// The read register can be cleared so stores and errors present zero data.
module dmem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  we,
    input  logic                  clr,
    input  logic [DEPTH_LOG2-1:0] index,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    // NOTE: the storage array has no reset so it maps onto block RAM; only the
    // read register is cleared.
    always_ff @(posedge clock) begin
        if (en && we) begin
            mem[index] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage responder: accepts one load/store at a time over valid/ready,
// waits LATENCY cycles, accesses the data RAM and pulses respValid.
module data_mem_responder
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic                  respValid,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  accessError,
    output logic                  stall
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                state;
    logic [CW-1:0]         counter;
    logic [DEPTH_LOG2-1:0] index_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;

    logic good_req;
    logic accept;
    logic error_accept;
    logic access;
    logic unused_addr_bits;

    // Address bits above the RAM index are deliberately ignored (wrap-around).
    assign unused_addr_bits = ^address[ADDR_WIDTH-1:DEPTH_LOG2+2];

    assign reqReady     = (state == IDLE) && !reset;
    assign stall        = reqValid && !reqReady;
    assign accept       = reqValid && reqReady;
    assign good_req     = (memRead ^ memWrite) && (address[1:0] == 2'b00);
    assign error_accept = accept && (memRead || memWrite) && !good_req;
    // Gating with reset keeps an abandoned store from committing on the reset edge.
    assign access       = (state == WAIT) && (counter == '0) && !reset;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            respValid   <= 1'b0;
            accessError <= 1'b0;
            counter     <= '0;
            index_q     <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    respValid <= 1'b0;
                    if (accept) begin
                        index_q <= address[DEPTH_LOG2+1:2];
                        wdata_q <= writeData;
                        write_q <= memWrite;
                        if (good_req) begin
                            state   <= WAIT;
                            counter <= CW'(LATENCY - 1);
                        end else if (memRead || memWrite) begin
                            state       <= RESP;
                            respValid   <= 1'b1;
                            accessError <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (counter == '0) begin
                        state       <= RESP;
                        respValid   <= 1'b1;
                        accessError <= 1'b0;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                RESP: begin
                    respValid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    respValid <= 1'b0;
                end
            endcase
        end
    end

    dmem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clock(clock),
        .reset(reset),
        .en   (access),
        .we   (write_q),
        .clr  (error_accept || (access && write_q)),
        .index(index_q),
        .wdata(wdata_q),
        .rdata(readData)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a driver pushes expected responses
// from a word-array reference model; a monitor pops them on every respValid.
module tb_data_mem_responder;

    localparam int LAT = 2;
    localparam int DL2 = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic        respValid;
    logic [31:0] readData;
    logic        accessError;
    logic        stall;

    data_mem_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(DL2), .LATENCY(LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .address    (address),
        .writeData  (writeData),
        .respValid  (respValid),
        .readData   (readData),
        .accessError(accessError),
        .stall      (stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [256];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (respValid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_data", readData, e.data);
                check("resp_err", {31'd0, accessError}, {31'd0, e.err});
                check("resp_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one request, holding it until accepted. When score is 0 no
    // response is expected (used for the transaction killed by reset).
    task automatic req(input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit score);
        int   n;
        int   idx;
        exp_t e;
        @(negedge clock);
        reqValid  = 1'b1;
        memRead   = r;
        memWrite  = w;
        address   = a;
        writeData = d;
        #1;
        n = 0;
        while (reqReady !== 1'b1) begin
            check("stall_while_busy", {31'd0, stall}, 32'd1);
            @(negedge clock);
            #1;
            n++;
            if (n > 50) begin
                check("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        idx = int'((a >> 2) % 256);
        if (score) begin
            if ((r ^ w) && a[1:0] == 2'b00) begin
                e.err = 1'b0;
                e.cyc = cyc + 1 + LAT;
                if (w) begin
                    model_mem[idx] = d;
                    e.data = 32'd0;
                end else begin
                    e.data = model_mem[idx];
                end
                sb.push_back(e);
            end else if (r || w) begin
                e.err  = 1'b1;
                e.data = 32'd0;
                e.cyc  = cyc + 1;
                sb.push_back(e);
            end
        end
        @(posedge clock);
    endtask

    task automatic go_idle();
        @(negedge clock);
        reqValid = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   k;
        int   n;
        logic [31:0] a;

        repeat (3) @(negedge clock);
        #1;
        check("reset_reqReady", {31'd0, reqReady}, 32'd0);
        check("reset_respValid", {31'd0, respValid}, 32'd0);
        check("reset_readData", readData, 32'd0);
        check("reset_accessError", {31'd0, accessError}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_reset_reqReady", {31'd0, reqReady}, 32'd1);

        // Store then load, misaligned load, conflicting op, wrap-around.
        req(0, 1, 32'h10, 32'hDEADBEEF, 1);
        req(1, 0, 32'h10, 32'h0, 1);
        req(1, 0, 32'h13, 32'h0, 1);
        req(1, 0, 32'h10, 32'h0, 1);
        req(1, 1, 32'h10, 32'h1, 1);
        req(1, 0, 32'h10, 32'h0, 1);
        req(0, 1, 32'h400, 32'h1, 1);
        req(1, 0, 32'h0, 32'h0, 1);

        // Reset while a store is waiting: store must not commit, no response.
        req(0, 1, 32'h20, 32'd7, 1);
        req(0, 1, 32'h20, 32'd5, 0);
        @(negedge clock);
        reqValid = 1'b0;
        reset    = 1'b1;
        #1;
        check("reset_mid_reqReady", {31'd0, reqReady}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        req(1, 0, 32'h20, 32'h0, 1);

        // Request held during a busy store is accepted exactly once.
        req(0, 1, 32'h30, 32'hA5A5_0F0F, 1);
        @(negedge clock);
        #1;
        check("busy_reqReady", {31'd0, reqReady}, 32'd0);
        req(1, 0, 32'h30, 32'h0, 1);
        go_idle();

        // Wait for outstanding work, then a NOP must be silently consumed.
        n = 0;
        while (sb.size() != 0 && n < 50) begin @(negedge clock); n++; end
        repeat (2) @(negedge clock);
        req(0, 0, 32'h44, 32'h1234, 1);
        go_idle();
        #1;
        check("nop_reqReady", {31'd0, reqReady}, 32'd1);
        @(negedge clock);
        #1;
        check("nop_no_resp", {31'd0, respValid}, 32'd0);

        // Randomised traffic over a 16-word pool with random high address bits.
        for (int i = 0; i < 16; i++) req(0, 1, i * 4, $urandom, 1);
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 9);
            a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
            if (k <= 3)      req(1, 0, a, $urandom, 1);
            else if (k <= 6) req(0, 1, a, $urandom, 1);
            else if (k == 7) req($urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 1'b0, a | 32'($urandom_range(1, 3)), $urandom, 1);
            else if (k == 8) req(1, 1, a, $urandom, 1);
            else             req(0, 0, a, $urandom, 1);
            if ($urandom_range(0, 3) == 0) go_idle();
        end
        go_idle();

        n = 0;
        while (sb.size() != 0 && n < 50) begin @(negedge clock); n++; end
        repeat (3) @(negedge clock);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
